// File: rtl/dcache_pkg.sv
// Shared geometry, FSM state type and word-select helpers for the direct-mapped L1 data cache.
package dcache_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_NUM_LINES  = 32;
    localparam int LINE_BITS      = 256;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = LINE_BITS / WORD_W;
    localparam int WORD_SEL_W     = $clog2(WORDS_PER_LINE);
    localparam int OFFSET_W       = 5;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    // Byte offset within a line -> 32-bit word number (byte lane bits dropped).
    function automatic logic [WORD_SEL_W-1:0] word_sel(input logic [OFFSET_W-1:0] offset);
        return WORD_SEL_W'(offset >> 2);
    endfunction

    function automatic logic [WORD_W-1:0] get_word(input logic [LINE_BITS-1:0] line,
                                                   input logic [WORD_SEL_W-1:0] sel);
        return line[sel*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port that
// either merges a single store word or installs a whole line from a fill.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int IDX_W     = $clog2(DEF_NUM_LINES),
    parameter int TAG_W     = DEF_ADDR_W - $clog2(DEF_NUM_LINES) - OFFSET_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      rd_index,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_BITS-1:0]  rd_line,
    input  logic                  wr_word_en,
    input  logic                  wr_line_en,
    input  logic [IDX_W-1:0]      wr_index,
    input  logic [WORD_SEL_W-1:0] wr_sel,
    input  logic [WORD_W-1:0]     wr_word,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [LINE_BITS-1:0]  wr_line
);

    logic [LINE_BITS-1:0] data_arr [NUM_LINES];
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;

    assign rd_valid = valid[rd_index];
    assign rd_dirty = dirty[rd_index];
    assign rd_tag   = tag_arr[rd_index];
    assign rd_line  = data_arr[rd_index];

    // NOTE: tag and data RAMs carry no reset; clearing valid alone makes their contents unreachable.
    always_ff @(posedge clk_i) begin
        if (wr_line_en) begin
            data_arr[wr_index] <= wr_line;
            tag_arr[wr_index]  <= wr_tag;
        end else if (wr_word_en) begin
            data_arr[wr_index][wr_sel*WORD_W +: WORD_W] <= wr_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= '0;
            dirty <= '0;
        end else if (wr_line_en) begin
            valid[wr_index] <= 1'b1;
            dirty[wr_index] <= 1'b0;
        end else if (wr_word_en) begin
            dirty[wr_index] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 data cache controller: hit compare,
// miss FSM (writeback then allocate) and registered memory-side request.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic [WORD_W-1:0]    cpu_wdata_i,
    output logic [WORD_W-1:0]    cpu_rdata_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFFSET_W;

    state_t                state;
    logic [IDX_W-1:0]      req_index;
    logic [IDX_W-1:0]      miss_index;
    logic [TAG_W-1:0]      req_tag;
    logic [TAG_W-1:0]      miss_tag;
    logic [WORD_SEL_W-1:0] req_word;
    logic                  rd_valid;
    logic                  rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [LINE_BITS-1:0]  rd_line;
    logic                  idle_hit;
    logic                  store_en;
    logic                  fill_en;

    assign req_index = cpu_addr_i[OFFSET_W +: IDX_W];
    assign req_tag   = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign req_word  = word_sel(cpu_addr_i[OFFSET_W-1:0]);

    assign idle_hit    = (state == IDLE) && cpu_req_i && rd_valid && (rd_tag == req_tag);
    assign cpu_stall_o = cpu_req_i && !idle_hit;
    assign cpu_rdata_o = idle_hit ? get_word(rd_line, req_word) : '0;
    assign store_en    = idle_hit && cpu_we_i;
    assign fill_en     = (state == ALLOCATE) && mem_ack_i;

    // Fills target the latched miss line, so a request dropped mid-miss cannot redirect them.
    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_index   (req_index),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_line    (rd_line),
        .wr_word_en (store_en),
        .wr_line_en (fill_en),
        .wr_index   (fill_en ? miss_index : req_index),
        .wr_sel     (req_word),
        .wr_word    (cpu_wdata_i),
        .wr_tag     (miss_tag),
        .wr_line    (mem_rdata_i)
    );

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            miss_index  <= '0;
            miss_tag    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_i && !idle_hit) begin
                        miss_index <= req_index;
                        miss_tag   <= req_tag;
                        mem_req_o  <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state       <= WRITEBACK;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= {rd_tag, req_index, {OFFSET_W{1'b0}}};
                            mem_wdata_o <= rd_line;
                        end else begin
                            state      <= ALLOCATE;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= {req_tag, req_index, {OFFSET_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state      <= ALLOCATE;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= {miss_tag, miss_index, {OFFSET_W{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: flat architectural memory model plus a
// latency-controlled memory responder that logs every line transfer.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int NL    = 32;
    localparam int AW    = 32;
    localparam int TAG_B = AW - $clog2(NL) - OFFSET_W;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 cpu_req_i;
    logic                 cpu_we_i;
    logic [AW-1:0]        cpu_addr_i;
    logic [31:0]          cpu_wdata_i;
    logic [31:0]          cpu_rdata_o;
    logic                 cpu_stall_o;
    logic                 mem_req_o;
    logic                 mem_we_o;
    logic [AW-1:0]        mem_addr_o;
    logic [LINE_BITS-1:0] mem_wdata_o;
    logic [LINE_BITS-1:0] mem_rdata_i;
    logic                 mem_ack_i;

    always #5 clk_i = ~clk_i;

    dcache_ctrl #(.NUM_LINES(NL), .ADDR_W(AW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Architectural view (what the CPU must see) and backing memory, word-addressed.
    logic [31:0]      arch_mem [int unsigned];
    logic [31:0]      ext_mem  [int unsigned];
    bit               mv [NL];
    bit               md [NL];
    logic [TAG_B-1:0] mt [NL];

    typedef struct {
        logic                 we;
        logic [AW-1:0]        addr;
        logic [LINE_BITS-1:0] wdata;
    } xfer_t;

    xfer_t xlog[$];
    int    mem_delay   = 0;
    bit    mem_busy    = 0;
    bit    stab_en     = 1;
    int    stable_viol = 0;

    function automatic logic [31:0] init_val(input int unsigned wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] rd_arch(input int unsigned wa);
        return arch_mem.exists(wa) ? arch_mem[wa] : init_val(wa);
    endfunction

    function automatic logic [31:0] rd_ext(input int unsigned wa);
        return ext_mem.exists(wa) ? ext_mem[wa] : init_val(wa);
    endfunction

    function automatic logic [LINE_BITS-1:0] arch_line(input logic [AW-1:0] base);
        logic [LINE_BITS-1:0] l;
        for (int w = 0; w < WORDS_PER_LINE; w++) l[w*32 +: 32] = rd_arch((base >> 2) + w);
        return l;
    endfunction

    // Memory responder: latches a request, waits mem_delay cycles checking stability, then acks.
    initial begin
        xfer_t x;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (mem_req_o === 1'b1 && rst_i === 1'b0) begin
                x.we = mem_we_o; x.addr = mem_addr_o; x.wdata = mem_wdata_o;
                xlog.push_back(x);
                mem_busy = 1;
                repeat (mem_delay) begin
                    @(negedge clk_i);
                    if (stab_en && (mem_req_o !== 1'b1 || mem_we_o !== x.we || mem_addr_o !== x.addr ||
                                    (x.we && mem_wdata_o !== x.wdata)))
                        stable_viol++;
                end
                if (x.we) begin
                    for (int w = 0; w < WORDS_PER_LINE; w++) ext_mem[(x.addr >> 2) + w] = x.wdata[w*32 +: 32];
                end else begin
                    for (int w = 0; w < WORDS_PER_LINE; w++) mem_rdata_i[w*32 +: 32] = rd_ext((x.addr >> 2) + w);
                end
                mem_ack_i = 1'b1;
                mem_busy  = 0;
            end
        end
    end

    // One CPU access, held until the stall drops; all expectations come from the models above.
    task automatic do_access(input bit we, input logic [AW-1:0] addr, input logic [31:0] wdata);
        logic [4:0]       idx;
        logic [TAG_B-1:0] tg;
        int unsigned      wa;
        bit               hit, wb, done;
        int               exp_stall, stall_cnt, exp_n;
        logic [AW-1:0]    vbase;
        logic [LINE_BITS-1:0] vline;
        logic [31:0]      exp_rd;
        idx = addr[9:5]; tg = addr[AW-1:10]; wa = addr >> 2;
        hit = mv[idx] && mt[idx] == tg;
        wb  = !hit && mv[idx] && md[idx];
        exp_stall = hit ? 0 : (mem_delay + 2 + (wb ? mem_delay + 1 : 0));
        exp_n = hit ? 0 : (wb ? 2 : 1);
        vbase = {mt[idx], idx, 5'b0};
        vline = arch_line(vbase);
        exp_rd = rd_arch(wa);
        xlog.delete();
        @(negedge clk_i);
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata;
        stall_cnt = 0; done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            #1;
            if (cpu_stall_o) begin stall_cnt++; @(negedge clk_i); end
            else done = 1;
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL stall_timeout addr=%h: stall never released", addr);
        end else begin
            if (stall_cnt !== exp_stall) begin
                tests_failed++;
                $display("FAIL stall_cycles addr=%h: got %0d expected %0d", addr, stall_cnt, exp_stall);
            end
            if (!we) begin
                tests_run++;
                if (cpu_rdata_o !== exp_rd) begin
                    tests_failed++;
                    $display("FAIL load_data addr=%h: got %h expected %h", addr, cpu_rdata_o, exp_rd);
                end
            end
            tests_run++;
            if (xlog.size() !== exp_n) begin
                tests_failed++;
                $display("FAIL xfer_count addr=%h: got %0d expected %0d", addr, xlog.size(), exp_n);
            end else if (!hit) begin
                if (wb) begin
                    tests_run++;
                    if (xlog[0].we !== 1'b1 || xlog[0].addr !== vbase || xlog[0].wdata !== vline) begin
                        tests_failed++;
                        $display("FAIL writeback addr=%h: got we=%b a=%h expected a=%h (data %0s)", addr,
                                 xlog[0].we, xlog[0].addr, vbase, xlog[0].wdata === vline ? "ok" : "wrong");
                    end
                end
                tests_run++;
                if (xlog[exp_n-1].we !== 1'b0 || xlog[exp_n-1].addr !== {addr[AW-1:5], 5'b0}) begin
                    tests_failed++;
                    $display("FAIL fill addr=%h: got we=%b a=%h expected we=0 a=%h", addr,
                             xlog[exp_n-1].we, xlog[exp_n-1].addr, {addr[AW-1:5], 5'b0});
                end
            end
        end
        @(posedge clk_i);
        if (!hit) begin mv[idx] = 1; mt[idx] = tg; md[idx] = 0; end
        if (we) begin md[idx] = 1; arch_mem[wa] = wdata; end
    endtask

    task automatic go_idle();
        @(negedge clk_i);
        cpu_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < NL; i++) begin mv[i] = 0; md[i] = 0; mt[i] = '0; end
        repeat (2) @(negedge clk_i);
        #1;
        tests_run++;
        if ({mem_req_o, mem_we_o, cpu_stall_o} !== 3'b000 || mem_addr_o !== '0 || cpu_rdata_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got req=%b we=%b stall=%b addr=%h rdata=%h expected all 0",
                     mem_req_o, mem_we_o, cpu_stall_o, mem_addr_o, cpu_rdata_o);
        end
    endtask

    task automatic test_cold_load();
        mem_delay = 2;
        ext_mem[32'h48 >> 2]  = 32'hDEAD_BEEF;
        arch_mem[32'h48 >> 2] = 32'hDEAD_BEEF;
        do_access(0, 32'h40, '0);
        do_access(0, 32'h48, '0);
        go_idle();
    endtask

    task automatic test_store_hit();
        do_access(1, 32'h44, 32'h1234_5678);
        do_access(0, 32'h44, '0);
        go_idle();
    endtask

    task automatic test_writeback();
        mem_delay = 3;
        do_access(0, 32'h440, '0);
        do_access(0, 32'h40, '0);
        go_idle();
    endtask

    task automatic test_store_miss_clean();
        mem_delay = 1;
        do_access(1, 32'h88, 32'hCAFE_F00D);
        do_access(0, 32'h88, '0);
        do_access(0, 32'h880, '0);
        go_idle();
    endtask

    task automatic test_delayed_ack();
        mem_delay = 15;
        stable_viol = 0;
        do_access(1, 32'h1040, 32'h0BAD_CAFE);
        do_access(0, 32'h3040, '0);
        go_idle();
        tests_run++;
        if (stable_viol !== 0) begin
            tests_failed++;
            $display("FAIL req_stability: got %0d unstable cycles expected 0", stable_viol);
        end
    endtask

    task automatic test_back_to_back();
        mem_delay = 1;
        for (int w = 0; w < 8; w++) do_access(w[0], 32'h3040 + 32'(w * 4), 32'hB0B0_0000 + 32'(w));
        for (int w = 0; w < 8; w++) do_access(0, 32'h3040 + 32'(w * 4), '0);
        go_idle();
    endtask

    task automatic test_deassert_mid_miss();
        bit done;
        mem_delay = 3;
        xlog.delete();
        @(negedge clk_i);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h140;
        @(negedge clk_i);
        cpu_req_i = 1'b0; cpu_addr_i = 32'h2;
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk_i); #1;
            if (mem_req_o === 1'b0 && !mem_busy && xlog.size() != 0) done = 1;
        end
        tests_run++;
        if (!done || xlog.size() !== 1 || xlog[0].addr !== 32'h140) begin
            tests_failed++;
            $display("FAIL abandoned_fill: got done=%b n=%0d expected one fill of 00000140", done, xlog.size());
        end
        mv[10] = 1; mt[10] = '0; md[10] = 0;
        do_access(0, 32'h144, '0);
        go_idle();
    endtask

    task automatic test_random();
        logic [TAG_B-1:0] tg;
        logic [4:0]       ix;
        logic [2:0]       wd;
        logic [1:0]       lo;
        stable_viol = 0;
        for (int n = 0; n < 160; n++) begin
            mem_delay = $urandom_range(0, 3);
            tg = TAG_B'($urandom_range(0, 3));
            ix = 5'($urandom_range(0, 3));
            wd = 3'($urandom_range(0, 7));
            lo = 2'($urandom_range(0, 3));
            do_access($urandom_range(0, 1) == 1, {tg, ix, wd, lo}, $urandom);
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();
        tests_run++;
        if (stable_viol !== 0) begin
            tests_failed++;
            $display("FAIL random_stability: got %0d unstable cycles expected 0", stable_viol);
        end
    endtask

    task automatic test_reset_mid_alloc();
        bit seen;
        mem_delay = 20;
        stab_en = 0;
        @(negedge clk_i);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h240;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk_i); #1;
            if (mem_req_o === 1'b1 && mem_we_o === 1'b0) seen = 1;
        end
        rst_i = 1'b1; cpu_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        tests_run++;
        if (!seen || mem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_alloc: got seen=%b mem_req=%b expected seen=1 mem_req=0", seen, mem_req_o);
        end
        for (int c = 0; c < 100 && mem_busy; c++) @(negedge clk_i);
        repeat (3) @(negedge clk_i);
        #1;
        tests_run++;
        if (mem_req_o !== 1'b0 || cpu_stall_o !== 1'b0 || mem_busy) begin
            tests_failed++;
            $display("FAIL late_ack_ignored: got mem_req=%b stall=%b busy=%b expected 0 0 0",
                     mem_req_o, cpu_stall_o, mem_busy);
        end
        for (int i = 0; i < NL; i++) begin mv[i] = 0; md[i] = 0; end
        arch_mem = ext_mem;
        stab_en = 1;
        mem_delay = 2;
        do_access(0, 32'h40, '0);
        do_access(0, 32'h44, '0);
        go_idle();
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_store_hit();
        test_writeback();
        test_store_miss_clean();
        test_delayed_ack();
        test_back_to_back();
        test_deassert_mid_miss();
        test_random();
        test_reset_mid_alloc();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
